// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with tick prescaler, parallel load, wrap pulse
// and a time-multiplexed 7-segment scan driver with optional leading-zero blanking.
module bcd_scan_counter #(
   parameter int NUM_DIGITS     = 3,
   parameter int TICK_DIV       = 1000000,
   parameter int SCAN_DIV       = 1000,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit SEL_ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    up_down,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic                    blank_lz,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    wrap
);

   localparam int CW = 4 * NUM_DIGITS;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      case (digit)
         4'd0:    seg_encode = 7'h3F;
         4'd1:    seg_encode = 7'h06;
         4'd2:    seg_encode = 7'h5B;
         4'd3:    seg_encode = 7'h4F;
         4'd4:    seg_encode = 7'h66;
         4'd5:    seg_encode = 7'h6D;
         4'd6:    seg_encode = 7'h7D;
         4'd7:    seg_encode = 7'h07;
         4'd8:    seg_encode = 7'h7F;
         4'd9:    seg_encode = 7'h6F;
         default: seg_encode = 7'h00;
      endcase
   endfunction

   logic [PW-1:0]         pcnt_r;
   logic [SW-1:0]         scnt_r;
   logic [IW-1:0]         digit_idx_r;
   logic [CW-1:0]         count_r;
   logic                  wrap_r;
   logic [6:0]            seg_r;
   logic [NUM_DIGITS-1:0] sel_r;

   logic                  tick_s;
   logic                  carry_s;
   logic                  step_wrap_s;
   logic [CW-1:0]         step_count_s;
   logic [CW-1:0]         load_clean_s;
   logic [NUM_DIGITS:0]   zero_from_s;
   logic [3:0]            digit_val_s;
   logic                  blank_s;
   logic [NUM_DIGITS-1:0] sel_raw_s;
   logic [6:0]            seg_raw_s;

   assign tick_s = enable && (pcnt_r == PW'(TICK_DIV - 1));

   // Next count for one tick: ripple carry (up) or borrow (down) through the digits
   always_comb begin
      step_count_s = count_r;
      carry_s      = 1'b1;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (carry_s) begin
            if (up_down) begin
               if (count_r[4*d +: 4] == 4'd9) begin
                  step_count_s[4*d +: 4] = 4'd0;
               end else begin
                  step_count_s[4*d +: 4] = count_r[4*d +: 4] + 4'd1;
                  carry_s                = 1'b0;
               end
            end else begin
               if (count_r[4*d +: 4] == 4'd0) begin
                  step_count_s[4*d +: 4] = 4'd9;
               end else begin
                  step_count_s[4*d +: 4] = count_r[4*d +: 4] - 4'd1;
                  carry_s                = 1'b0;
               end
            end
         end else begin
            step_count_s[4*d +: 4] = count_r[4*d +: 4];
         end
      end
      step_wrap_s = carry_s;
   end

   // Non-BCD load nibbles are forced to zero so the count never holds an illegal digit
   always_comb begin
      load_clean_s = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         load_clean_s[4*d +: 4] = (load_value[4*d +: 4] > 4'd9) ? 4'd0 : load_value[4*d +: 4];
      end
   end

   // Prescaler, count register and wrap pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_r  <= '0;
         count_r <= '0;
         wrap_r  <= 1'b0;
      end else if (load) begin
         pcnt_r  <= '0;
         count_r <= load_clean_s;
         wrap_r  <= 1'b0;
      end else if (tick_s) begin
         pcnt_r  <= '0;
         count_r <= step_count_s;
         wrap_r  <= step_wrap_s;
      end else begin
         pcnt_r  <= enable ? pcnt_r + PW'(1) : pcnt_r;
         count_r <= count_r;
         wrap_r  <= 1'b0;
      end
   end

   // Free-running scan timer and digit index
   always_ff @(posedge clk) begin
      if (rst) begin
         scnt_r      <= '0;
         digit_idx_r <= '0;
      end else if (scnt_r == SW'(SCAN_DIV - 1)) begin
         scnt_r      <= '0;
         digit_idx_r <= (digit_idx_r == IW'(NUM_DIGITS - 1)) ? IW'(0) : digit_idx_r + IW'(1);
      end else begin
         scnt_r      <= scnt_r + SW'(1);
         digit_idx_r <= digit_idx_r;
      end
   end

   // zero_from_s[d] is set when digits d and above are all zero
   always_comb begin
      zero_from_s             = '0;
      zero_from_s[NUM_DIGITS] = 1'b1;
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         zero_from_s[d] = zero_from_s[d+1] & (count_r[4*d +: 4] == 4'd0);
      end
   end

   // Select the displayed digit and decide whether it is a blanked leading zero
   always_comb begin
      digit_val_s = 4'd0;
      blank_s     = 1'b0;
      sel_raw_s   = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (digit_idx_r == IW'(d)) begin
            digit_val_s  = count_r[4*d +: 4];
            sel_raw_s[d] = 1'b1;
            blank_s      = blank_lz & zero_from_s[d] & (d != 0);
         end else begin
            sel_raw_s[d] = 1'b0;
         end
      end
      seg_raw_s = blank_s ? 7'h00 : seg_encode(digit_val_s);
   end

   // Registered pin drivers with polarity applied
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_r <= SEG_OFF;
         sel_r <= SEL_OFF;
      end else begin
         seg_r <= SEG_ACTIVE_LOW ? ~seg_raw_s : seg_raw_s;
         sel_r <= SEL_ACTIVE_LOW ? ~sel_raw_s : sel_raw_s;
      end
   end

   assign seg_out   = seg_r;
   assign digit_sel = sel_r;
   assign count_bcd = count_r;
   assign wrap      = wrap_r;

endmodule
